filter_top_scanline: RTL and testbench

FILTER_TOP_SCANLINE -- requirements
Module: filter_top

---
 rtl/filter_top_scanline.sv | 140 ++++++++++++++
 tb/tb_filter_top_scanline.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/filter_top_scanline.sv
// PNG Paeth (filter type 4) scanline encoder for RGBA pixels: emits a header
// word per scanline, then one filtered word per accepted pixel, one cycle later.
module filter_top_scanline #(
  parameter int DATA_PXL_WD = 32,
  parameter int SIZE_W_WD   = 12,
  parameter int SIZE_H_WD   = 12,
  parameter int MAX_W       = 4095
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [SIZE_W_WD-1:0]   cfg_w_i,
  input  logic [SIZE_H_WD-1:0]   cfg_h_i,
  input  logic                   start_i,
  output logic                   done_o,
  input  logic                   val_i,
  input  logic [DATA_PXL_WD-1:0] dat_i,
  output logic                   fifo_flt_wr_val_o,
  output logic [DATA_PXL_WD-1:0] fifo_flt_wr_dat_o
);

  localparam int NLANE = DATA_PXL_WD / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state_q;
  logic [SIZE_H_WD-1:0]   row_q;
  logic [SIZE_W_WD-1:0]   pix_cnt_q;
  logic [DATA_PXL_WD-1:0] left_q;
  logic [DATA_PXL_WD-1:0] ul_q;
  logic                   done_q;
  logic                   out_val_q;
  logic [DATA_PXL_WD-1:0] out_dat_q;

  logic [DATA_PXL_WD-1:0] line_mem [MAX_W];
  logic [DATA_PXL_WD-1:0] above_d;
  logic [DATA_PXL_WD-1:0] filt_d;
  logic                   accept_d;
  logic                   last_pix_d;
  logic                   last_row_d;

  function automatic logic [7:0] paeth_lane(input logic [7:0] x, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] c);
    logic signed [9:0] p;
    logic signed [9:0] da;
    logic signed [9:0] db;
    logic signed [9:0] dc;
    logic signed [9:0] pa;
    logic signed [9:0] pb;
    logic signed [9:0] pc;
    logic [7:0]        pred;
    p  = $signed({2'b00, a}) + $signed({2'b00, b}) - $signed({2'b00, c});
    da = p - $signed({2'b00, a});
    db = p - $signed({2'b00, b});
    dc = p - $signed({2'b00, c});
    pa = (da < 0) ? -da : da;
    pb = (db < 0) ? -db : db;
    pc = (dc < 0) ? -dc : dc;
    if (pa <= pb && pa <= pc) begin
      pred = a;
    end else if (pb <= pc) begin
      pred = b;
    end else begin
      pred = c;
    end
    return x - pred;
  endfunction

  assign accept_d   = (state_q == BUSY) && val_i;
  assign last_pix_d = (pix_cnt_q == cfg_w_i - 1'b1);
  assign last_row_d = (row_q == cfg_h_i - 1'b1);

  // Row 0 has no valid previous line, so stale buffer contents are masked here.
  assign above_d = (row_q == '0) ? '0 : line_mem[pix_cnt_q];

  always_comb begin
    filt_d = '0;
    for (int unsigned k = 0; k < NLANE; k++) begin
      filt_d[8*k +: 8] = paeth_lane(dat_i[8*k +: 8], left_q[8*k +: 8],
                                    above_d[8*k +: 8], ul_q[8*k +: 8]);
    end
  end

  // Read of entry i (above_d) happens in the same cycle this write is scheduled.
  always_ff @(posedge clk) begin
    if (accept_d) begin
      line_mem[pix_cnt_q] <= dat_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      row_q     <= '0;
      pix_cnt_q <= '0;
      left_q    <= '0;
      ul_q      <= '0;
      done_q    <= 1'b0;
      out_val_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      done_q    <= 1'b0;
      out_val_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q   <= BUSY;
            pix_cnt_q <= '0;
            left_q    <= '0;
            ul_q      <= '0;
            out_val_q <= 1'b1;
            out_dat_q <= DATA_PXL_WD'(4);
          end
        end
        BUSY: begin
          if (val_i) begin
            out_val_q <= 1'b1;
            out_dat_q <= filt_d;
            left_q    <= dat_i;
            ul_q      <= above_d;
            pix_cnt_q <= pix_cnt_q + 1'b1;
            if (last_pix_d) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              row_q   <= last_row_d ? '0 : row_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done_o            = done_q;
  assign fifo_flt_wr_val_o = out_val_q;
  assign fifo_flt_wr_dat_o = out_dat_q;

endmodule

// File: tb/tb_filter_top_scanline.sv
// Directed bench for filter_top_scanline: hand vectors plus an independent
// Paeth reference model and row-counter tracking for longer sequences.
module tb_filter_top_scanline;

  logic        clk;
  logic        rstn;
  logic [11:0] cfg_w_i;
  logic [11:0] cfg_h_i;
  logic        start_i;
  logic        done_o;
  logic        val_i;
  logic [31:0] dat_i;
  logic        fifo_flt_wr_val_o;
  logic [31:0] fifo_flt_wr_dat_o;

  int total = 0;
  int bad   = 0;
  int rowm  = 0;

  logic [31:0] cur  [256];
  logic [31:0] prev [256];
  logic [31:0] obs  [256];

  filter_top_scanline #(
    .DATA_PXL_WD(32),
    .SIZE_W_WD  (12),
    .SIZE_H_WD  (12),
    .MAX_W      (4095)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .cfg_w_i          (cfg_w_i),
    .cfg_h_i          (cfg_h_i),
    .start_i          (start_i),
    .done_o           (done_o),
    .val_i            (val_i),
    .dat_i            (dat_i),
    .fifo_flt_wr_val_o(fifo_flt_wr_val_o),
    .fifo_flt_wr_dat_o(fifo_flt_wr_dat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_paeth(input logic [31:0] x, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] c);
    logic [31:0] r;
    int ai, bi, ci, p, pa, pb, pc, pr;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      ai = int'(a[8*k +: 8]);
      bi = int'(b[8*k +: 8]);
      ci = int'(c[8*k +: 8]);
      p  = ai + bi - ci;
      pa = (p > ai) ? p - ai : ai - p;
      pb = (p > bi) ? p - bi : bi - p;
      pc = (p > ci) ? p - ci : ci - p;
      if (pa <= pb && pa <= pc) pr = ai;
      else if (pb <= pc) pr = bi;
      else pr = ci;
      r[8*k +: 8] = 8'(int'(x[8*k +: 8]) - pr);
    end
    return r;
  endfunction

  function automatic logic [31:0] pat(input int r, input int i);
    return {8'(r * 7 + i), 8'(r ^ i), 8'(i * 3 + r), 8'(255 - i - r)};
  endfunction

  // One scanline of cur[0..w-1]; gap idle cycles after each pixel; start_i is
  // also raised alongside pixel index start_at (-1 for never).
  task automatic run_row(input int w, input int gap, input int start_at, input int h);
    logic [31:0] a, b, c, e;
    int strobes, dones;
    bit r0;
    r0 = (rowm == 0);
    strobes = 0;
    dones = 0;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    chk("hdr_val", 32'(fifo_flt_wr_val_o), 32'd1);
    chk("hdr_dat", fifo_flt_wr_dat_o, 32'h0000_0004);
    chk("hdr_done", 32'(done_o), 32'd0);
    strobes += int'(fifo_flt_wr_val_o);
    for (int i = 0; i < w; i++) begin
      val_i   = 1'b1;
      dat_i   = cur[i];
      start_i = (i == start_at);
      cyc();
      val_i   = 1'b0;
      start_i = 1'b0;
      a = (i == 0) ? 32'h0 : cur[i-1];
      b = r0 ? 32'h0 : prev[i];
      c = (r0 || i == 0) ? 32'h0 : prev[i-1];
      e = ref_paeth(cur[i], a, b, c);
      obs[i] = fifo_flt_wr_dat_o;
      chk("pix_val", 32'(fifo_flt_wr_val_o), 32'd1);
      chk("pix_dat", fifo_flt_wr_dat_o, e);
      chk("pix_done", 32'(done_o), (i == w - 1) ? 32'd1 : 32'd0);
      strobes += int'(fifo_flt_wr_val_o);
      dones   += int'(done_o);
      for (int g = 0; g < gap; g++) begin
        cyc();
        chk("gap_val", 32'(fifo_flt_wr_val_o), 32'd0);
        strobes += int'(fifo_flt_wr_val_o);
        dones   += int'(done_o);
      end
    end
    for (int t = 0; t < 2; t++) begin
      val_i = 1'b1;
      dat_i = 32'hDEAD_BEEF;
      cyc();
      chk("idle_val", 32'(fifo_flt_wr_val_o), 32'd0);
      chk("idle_hold", fifo_flt_wr_dat_o, obs[w-1]);
      strobes += int'(fifo_flt_wr_val_o);
      dones   += int'(done_o);
    end
    val_i = 1'b0;
    chk("strobes", 32'(strobes), 32'(w + 1));
    chk("dones", 32'(dones), 32'd1);
    for (int i = 0; i < w; i++) prev[i] = cur[i];
    rowm = (rowm + 1 == h) ? 0 : rowm + 1;
  endtask

  initial begin
    rstn    = 1'b0;
    cfg_w_i = 12'd4;
    cfg_h_i = 12'd2;
    start_i = 1'b0;
    val_i   = 1'b0;
    dat_i   = '0;
    for (int i = 0; i < 256; i++) prev[i] = '0;
    repeat (3) cyc();
    chk("rst_val", 32'(fifo_flt_wr_val_o), 32'd0);
    chk("rst_dat", fifo_flt_wr_dat_o, 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    rstn = 1'b1;
    cyc();

    // Row 0 and identical row 1, W=4 H=2
    cur[0] = 32'h1020_3040; cur[1] = 32'h1122_3344;
    cur[2] = 32'h1224_3648; cur[3] = 32'h0102_0304;
    run_row(4, 0, -1, 2);
    chk("r0_p0", obs[0], 32'h1020_3040);
    chk("r0_p1", obs[1], 32'h0102_0304);
    chk("r0_p2", obs[2], 32'h0102_0304);
    chk("r0_p3", obs[3], 32'hEFDE_CDBC);
    run_row(4, 0, -1, 2);
    for (int i = 0; i < 4; i++) chk("r1_zero", obs[i], 32'h0);

    // Gap test on the wrapped (row 0) image, W=3
    cfg_w_i = 12'd3;
    cur[0] = 32'h0101_0101; cur[1] = 32'h0303_0303; cur[2] = 32'h0202_0202;
    run_row(3, 2, -1, 2);
    chk("gap_p0", obs[0], 32'h0101_0101);
    chk("gap_p1", obs[1], 32'h0202_0202);
    chk("gap_p2", obs[2], 32'hFFFF_FFFF);

    // Single-pixel scanline (row 1)
    cfg_w_i = 12'd1;
    cur[0] = 32'h8040_2010;
    run_row(1, 0, -1, 2);
    chk("w1_p0", obs[0], 32'h7F3F_1F0F);

    // start_i while BUSY, including on the last accepted pixel
    cfg_w_i = 12'd4;
    for (int i = 0; i < 4; i++) cur[i] = pat(5, i);
    run_row(4, 0, 1, 2);
    for (int i = 0; i < 4; i++) cur[i] = pat(9, i);
    run_row(4, 0, 3, 2);

    // Reset mid-scanline after two pixels
    for (int i = 0; i < 4; i++) cur[i] = pat(11, i);
    run_row(4, 0, -1, 2);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      val_i = 1'b1;
      dat_i = pat(13, i);
      cyc();
    end
    val_i = 1'b0;
    rstn  = 1'b0;
    #1;
    chk("mid_rst_val", 32'(fifo_flt_wr_val_o), 32'd0);
    chk("mid_rst_dat", fifo_flt_wr_dat_o, 32'd0);
    chk("mid_rst_done", 32'(done_o), 32'd0);
    cyc();
    rstn = 1'b1;
    rowm = 0;
    cyc();
    for (int i = 0; i < 4; i++) cur[i] = pat(17, i);
    run_row(4, 0, -1, 2);
    chk("post_rst_p0", obs[0], pat(17, 0));
    for (int i = 0; i < 4; i++) cur[i] = pat(19, i);
    run_row(4, 0, -1, 2);

    // Full image W=256 H=256, then a row that must start a new image
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    rowm = 0;
    cfg_w_i = 12'd256;
    cfg_h_i = 12'd256;
    cyc();
    for (int r = 0; r < 256; r++) begin
      for (int i = 0; i < 256; i++) cur[i] = pat(r, i);
      run_row(256, 0, -1, 256);
    end
    chk("wrap_row", 32'(rowm), 32'd0);
    for (int i = 0; i < 256; i++) cur[i] = pat(300, i);
    run_row(256, 0, -1, 256);
    chk("wrap_p0", obs[0], pat(300, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
